// File: rtl/fft16_pkg.sv
// Shared widths, complex types, twiddle table and saturation helper
// for the 16-point FFT datapath.
package fft16_pkg;
   localparam int DW = 17;
   localparam int TW = 17;
   localparam int LW = 34;
   localparam int BW = 136;

   typedef struct packed {
      logic signed [DW-1:0] im;
      logic signed [DW-1:0] re;
   } cplx_t;

   typedef struct packed {
      logic signed [TW-1:0] wi;
      logic signed [TW-1:0] wr;
   } twid_t;

   typedef struct packed {
      logic                 ovf;
      logic signed [DW-1:0] val;
   } sat_t;

   function automatic sat_t sat_dw(input logic signed [23:0] v);
      sat_t s;
      if (v > 24'sd65535) begin
         s.ovf = 1'b1;
         s.val = 17'h0FFFF;
      end else if (v < -24'sd65536) begin
         s.ovf = 1'b1;
         s.val = 17'h10000;
      end else begin
         s.ovf = 1'b0;
         s.val = v[DW-1:0];
      end
      return s;
   endfunction

   // wi holds -sin so the product below is an ordinary complex multiply.
   function automatic twid_t twiddle(input logic [3:0] m);
      twid_t w;
      case (m)
         4'd1:    begin w.wr =  17'sd30274; w.wi = -17'sd12540; end
         4'd2:    begin w.wr =  17'sd23170; w.wi = -17'sd23170; end
         4'd3:    begin w.wr =  17'sd12540; w.wi = -17'sd30274; end
         4'd4:    begin w.wr =  17'sd0;     w.wi = -17'sd32768; end
         4'd6:    begin w.wr = -17'sd23170; w.wi = -17'sd23170; end
         4'd9:    begin w.wr = -17'sd30274; w.wi =  17'sd12540; end
         default: begin w.wr =  17'sd32768; w.wi =  17'sd0;     end
      endcase
      return w;
   endfunction
endpackage

// File: rtl/fft16_r4_col_stage_if.sv
// Beat bus into and out of the radix-4 column stage.
interface fft16_r4_col_stage_if;
   import fft16_pkg::*;

   // in_valid qualifies in_sof/data_in every cycle; there is no ready, the
   // stage and its consumer accept one beat per cycle unconditionally.
   logic          in_valid;
   logic          in_sof;
   logic [BW-1:0] data_in;
   logic          out_valid;
   logic          out_last;
   logic [BW-1:0] data_out;

   modport master (output in_valid, in_sof, data_in,
                   input  out_valid, out_last, data_out);
   modport slave  (input  in_valid, in_sof, data_in,
                   output out_valid, out_last, data_out);
endinterface

// File: rtl/fft16_cmul_rnd.sv
// One lane of twiddle multiply: full-precision product in S2, Q15 round
// and 17-bit saturation in S3.
module fft16_cmul_rnd
   import fft16_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  s2_en,
   input  logic  s3_en,
   input  cplx_t a,
   input  twid_t w,
   output cplx_t y,
   output logic  sat
);
   logic signed [DW-1:0] ar, ai;
   logic signed [TW-1:0] wr, wi;
   logic signed [35:0]   p_re, p_im;
   logic signed [35:0]   r_re, r_im;
   sat_t                 s_re, s_im;

   assign ar = a.re;
   assign ai = a.im;
   assign wr = w.wr;
   assign wi = w.wi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_re <= '0;
         p_im <= '0;
      end else if (s2_en) begin
         p_re <= 36'(ar) * 36'(wr) - 36'(ai) * 36'(wi);
         p_im <= 36'(ar) * 36'(wi) + 36'(ai) * 36'(wr);
      end
   end

   always_comb begin
      r_re = p_re + 36'sd16384;
      r_im = p_im + 36'sd16384;
      s_re = sat_dw(24'(r_re >>> 15));
      s_im = sat_dw(24'(r_im >>> 15));
   end

   assign sat = s3_en & (s_re.ovf | s_im.ovf);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y <= '0;
      end else if (s3_en) begin
         y.re <= s_re.val;
         y.im <= s_im.val;
      end
   end
endmodule

// File: rtl/fft16_r4_col_stage.sv
// First FFT16 stage: radix-4 butterfly across the four lanes of a beat,
// then per-lane twiddle W16^(beat*lane); three-cycle pipeline.
module fft16_r4_col_stage
   import fft16_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   fft16_r4_col_stage_if.slave  bus,
   input  logic                 sat_clr,
   output logic                 sat_flag
);
   logic signed [DW-1:0] xr [4];
   logic signed [DW-1:0] xi [4];
   logic signed [18:0]   yr [4];
   logic signed [18:0]   yi [4];
   sat_t                 sr [4];
   sat_t                 si [4];
   cplx_t [3:0]          y_bf;
   logic                 bf_ovf;
   logic                 bf_sat;

   logic [1:0]  beat_cnt, cur_beat;
   logic        s1_valid, s2_valid, s2_last;
   logic [1:0]  s1_beat;
   cplx_t [3:0] s1_y;
   cplx_t [3:0] y_out;
   logic [3:0]  mul_sat;

   function automatic sat_t scale_sat(input logic signed [18:0] v);
      logic signed [19:0] t;
      t = 20'(v) + 20'sd2;
      return sat_dw(24'(t >>> 2));
   endfunction

   always_comb begin
      for (int l = 0; l < 4; l++) begin
         xr[l] = bus.data_in[LW*l +: DW];
         xi[l] = bus.data_in[LW*l+DW +: DW];
      end
   end

   // -j*(r+ji) = i - jr, so the odd outputs swap re/im of lanes b and d.
   always_comb begin
      yr[0] = 19'(xr[0]) + 19'(xr[1]) + 19'(xr[2]) + 19'(xr[3]);
      yi[0] = 19'(xi[0]) + 19'(xi[1]) + 19'(xi[2]) + 19'(xi[3]);
      yr[1] = 19'(xr[0]) + 19'(xi[1]) - 19'(xr[2]) - 19'(xi[3]);
      yi[1] = 19'(xi[0]) - 19'(xr[1]) - 19'(xi[2]) + 19'(xr[3]);
      yr[2] = 19'(xr[0]) - 19'(xr[1]) + 19'(xr[2]) - 19'(xr[3]);
      yi[2] = 19'(xi[0]) - 19'(xi[1]) + 19'(xi[2]) - 19'(xi[3]);
      yr[3] = 19'(xr[0]) - 19'(xi[1]) - 19'(xr[2]) + 19'(xi[3]);
      yi[3] = 19'(xi[0]) + 19'(xr[1]) - 19'(xi[2]) - 19'(xr[3]);
   end

   always_comb begin
      bf_ovf = 1'b0;
      y_bf   = '0;
      for (int k = 0; k < 4; k++) begin
         sr[k]      = scale_sat(yr[k]);
         si[k]      = scale_sat(yi[k]);
         y_bf[k].re = sr[k].val;
         y_bf[k].im = si[k].val;
         bf_ovf     = bf_ovf | sr[k].ovf | si[k].ovf;
      end
   end

   assign bf_sat   = bus.in_valid & bf_ovf;
   assign cur_beat = bus.in_sof ? 2'd0 : beat_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= 2'd0;
         s1_valid <= 1'b0;
         s1_beat  <= 2'd0;
         s1_y     <= '0;
      end else begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            beat_cnt <= cur_beat + 2'd1;
            s1_beat  <= cur_beat;
            s1_y     <= y_bf;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid      <= 1'b0;
         s2_last       <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
      end else begin
         s2_valid      <= s1_valid;
         s2_last       <= s1_valid & (s1_beat == 2'd3);
         bus.out_valid <= s2_valid;
         bus.out_last  <= s2_last;
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_lane
      twid_t w_k;
      assign w_k = twiddle(4'(s1_beat) * 4'(k));

      fft16_cmul_rnd u_cmul (
         .clk   (clk),
         .rst_n (rst_n),
         .s2_en (s1_valid),
         .s3_en (s2_valid),
         .a     (s1_y[k]),
         .w     (w_k),
         .y     (y_out[k]),
         .sat   (mul_sat[k])
      );
   end

   assign bus.data_out = y_out;

   // A new saturation outranks a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    sat_flag <= 1'b0;
      else if (bf_sat | (|mul_sat))  sat_flag <= 1'b1;
      else if (sat_clr)              sat_flag <= 1'b0;
   end
endmodule

// File: tb/tb_fft16_r4_col_stage.sv
// Bench for the FFT16 radix-4 column stage: directed frames plus random
// traffic checked against a complex-arithmetic reference model.
module tb_fft16_r4_col_stage;
   import fft16_pkg::*;

   logic clk, rst_n, sat_clr, sat_flag;

   fft16_r4_col_stage_if bus ();

   fft16_r4_col_stage dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .sat_clr  (sat_clr),
      .sat_flag (sat_flag)
   );

   int            n_vec, n_err, cyc, mcnt;
   bit            model_sat;
   logic [BW-1:0] exp_q[$];
   bit            exp_last_q[$];
   int            exp_cyc_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- check helpers ----------------
   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %b, want %b", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [33:0] lane(input int re, input int im);
      logic [16:0] r, i;
      r = re[16:0];
      i = im[16:0];
      return {i, r};
   endfunction

   function automatic logic [BW-1:0] beat4(input logic [33:0] l0, input logic [33:0] l1,
                                           input logic [33:0] l2, input logic [33:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic int cosq(input int m);
      int q[5] = '{32768, 30274, 23170, 12540, 0};
      int mm;
      mm = m % 16;
      if (mm <= 4)       return q[mm];
      else if (mm <= 8)  return -q[8-mm];
      else if (mm <= 12) return -q[mm-8];
      else               return q[16-mm];
   endfunction

   function automatic int clamp(input longint v, inout bit s);
      if (v > 65535)  begin s = 1'b1; return 65535;  end
      if (v < -65536) begin s = 1'b1; return -65536; end
      return int'(v);
   endfunction

   // Y_k = sum_l x_l * (-j)^(l*k), scaled by 1/4, then times W16^(b*k).
   function automatic logic [BW-1:0] model_beat(input logic [BW-1:0] d, input int b, output bit sat);
      int xr[4], xi[4];
      int yr, yi, r, i, wr, wi, m;
      longint pr, pi;
      logic [BW-1:0] o;
      sat = 1'b0;
      o   = '0;
      for (int l = 0; l < 4; l++) begin
         xr[l] = int'($signed(d[34*l +: 17]));
         xi[l] = int'($signed(d[34*l+17 +: 17]));
      end
      for (int k = 0; k < 4; k++) begin
         yr = 0;
         yi = 0;
         for (int l = 0; l < 4; l++) begin
            case ((l * k) % 4)
               0:       begin r =  xr[l]; i =  xi[l]; end
               1:       begin r =  xi[l]; i = -xr[l]; end
               2:       begin r = -xr[l]; i = -xi[l]; end
               default: begin r = -xi[l]; i =  xr[l]; end
            endcase
            yr += r;
            yi += i;
         end
         yr = clamp(longint'((yr + 2) >>> 2), sat);
         yi = clamp(longint'((yi + 2) >>> 2), sat);
         m  = b * k;
         wr = cosq(m);
         wi = -cosq(m + 12);
         pr = longint'(yr) * wr - longint'(yi) * wi;
         pi = longint'(yr) * wi + longint'(yi) * wr;
         r  = clamp((pr + 16384) >>> 15, sat);
         i  = clamp((pi + 16384) >>> 15, sat);
         o[34*k +: 34] = lane(r, i);
      end
      return o;
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic int rand_comp();
      case ($urandom_range(0, 3))
         0:       return ($urandom_range(0, 1) != 0) ? 65535 : -65536;
         1, 2:    return int'($urandom_range(0, 131071)) - 65536;
         default: return int'($urandom_range(0, 2000)) - 1000;
      endcase
   endfunction

   function automatic logic [BW-1:0] rand_beat();
      logic [BW-1:0] d;
      for (int l = 0; l < 4; l++) d[34*l +: 34] = lane(rand_comp(), rand_comp());
      return d;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input bit v, input bit sof, input logic [BW-1:0] d);
      bit s;
      int b;
      @(posedge clk);
      #1;
      bus.in_valid = v;
      bus.in_sof   = sof;
      bus.data_in  = d;
      sat_clr      = 1'b0;
      if (v) begin
         b    = sof ? 0 : mcnt;
         mcnt = (b + 1) % 4;
         exp_q.push_back(model_beat(d, b, s));
         model_sat = model_sat | s;
         exp_last_q.push_back(b == 3);
         exp_cyc_q.push_back(cyc + 3);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), rand_beat());
   endtask

   task automatic pulse_clr();
      drive(1'b0, 1'b0, rand_beat());
      sat_clr = 1'b1;
      drive(1'b0, 1'b0, rand_beat());
      model_sat = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, "_out_valid"}, bus.out_valid, 1'b0);
      chk1({tag, "_out_last"}, bus.out_last, 1'b0);
      chk({tag, "_data_out"}, bus.data_out, '0);
      chk1({tag, "_sat_flag"}, sat_flag, 1'b0);
   endtask

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin : cmp_blk
      bit exp_now;
      if (rst_n) begin
         exp_now = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
         chk1("out_valid", bus.out_valid, exp_now);
         if (exp_now) begin
            if (bus.out_valid) begin
               chk("data_out", bus.data_out, exp_q[0]);
               chk1("out_last", bus.out_last, exp_last_q[0]);
            end
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end else if (!bus.out_valid) begin
            chk1("out_last_idle", bus.out_last, 1'b0);
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [BW-1:0] dc_b, imp_b, tw_b, sat_b, z;
      bit s;

      rst_n        = 1'b0;
      sat_clr      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.data_in  = '0;
      mcnt         = 0;
      model_sat    = 1'b0;

      z     = '0;
      dc_b  = beat4(lane(400, 0), lane(400, 0), lane(400, 0), lane(400, 0));
      imp_b = beat4(lane(1000, 0), lane(0, 0), lane(0, 0), lane(0, 0));
      tw_b  = beat4(lane(0, 0), lane(4000, 0), lane(0, 0), lane(0, 0));
      sat_b = beat4(lane(65535, 0), lane(0, 65535), lane(-65536, 0), lane(0, -65536));

      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");

      // Hand-computed values that pin the model.
      chk("model_dc", model_beat(dc_b, 0, s),
          beat4(lane(400, 0), lane(0, 0), lane(0, 0), lane(0, 0)));
      chk("model_impulse", model_beat(imp_b, 0, s),
          beat4(lane(250, 0), lane(250, 0), lane(250, 0), lane(250, 0)));
      chk("model_twiddle", model_beat(tw_b, 1, s),
          beat4(lane(1000, 0), lane(-383, -924), lane(-707, 707), lane(924, 383)));
      chk("model_sat", model_beat(sat_b, 0, s),
          beat4(lane(0, 0), lane(65535, 0), lane(0, 0), lane(0, 0)));
      chk1("model_sat_flag", s, 1'b1);

      rst_n = 1'b1;

      // DC frame
      for (int bt = 0; bt < 4; bt++) drive(1'b1, bt == 0, dc_b);
      idle(6);
      chk1("dc_sat_flag", sat_flag, 1'b0);

      // Impulse
      drive(1'b1, 1'b1, imp_b);
      for (int bt = 1; bt < 4; bt++) drive(1'b1, 1'b0, z);
      idle(6);

      // Twiddle on beat 1
      drive(1'b1, 1'b1, z);
      drive(1'b1, 1'b0, tw_b);
      drive(1'b1, 1'b0, z);
      drive(1'b1, 1'b0, z);
      idle(6);

      // Saturation and sticky clear
      drive(1'b1, 1'b1, sat_b);
      for (int bt = 1; bt < 4; bt++) drive(1'b1, 1'b0, z);
      idle(6);
      chk1("sat_set", sat_flag, model_sat);
      idle(3);
      chk1("sat_sticky", sat_flag, 1'b1);
      pulse_clr();
      chk1("sat_cleared", sat_flag, 1'b0);

      // Gaps with a resync on the third beat
      for (int bt = 0; bt < 7; bt++) begin
         drive(1'b1, (bt == 0) || (bt == 2), rand_beat());
         idle(2);
      end
      idle(6);
      chk1("gap_sat_flag", sat_flag, model_sat);
      pulse_clr();

      // Reset mid-frame, then a frame without in_sof
      for (int bt = 0; bt < 3; bt++) drive(1'b1, bt == 0, rand_beat());
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      exp_last_q.delete();
      exp_cyc_q.delete();
      mcnt      = 0;
      model_sat = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int bt = 0; bt < 4; bt++) drive(1'b1, 1'b0, rand_beat());
      idle(6);
      chk1("postreset_sat_flag", sat_flag, model_sat);
      pulse_clr();

      // Random frames with gaps and occasional resync
      for (int f = 0; f < 40; f++) begin
         for (int bt = 0; bt < 4; bt++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            drive(1'b1,
                  ((bt == 0) && ($urandom_range(0, 3) != 0)) ||
                  ((bt == 2) && ($urandom_range(0, 9) == 0)),
                  rand_beat());
         end
         if (f % 10 == 9) begin
            idle(6);
            chk1("rand_sat_flag", sat_flag, model_sat);
            pulse_clr();
            chk1("rand_sat_clr", sat_flag, 1'b0);
         end
      end

      idle(6);
      chk1("queue_drained", exp_q.size() == 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
